// File: rtl/bin_to_bcd_param_if.sv
// Handshake and data bundle between the ALU result stage and the BCD converter.
// Names are from the converter's point of view: i_* enter it, o_* leave it.
interface bin_to_bcd_param_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
);
  logic                  i_start;
  logic                  i_signed_mode;
  logic [WIDTH-1:0]      i_binary_in;
  logic [4*DIGITS-1:0]   o_bcd_out;
  logic                  o_negative;
  logic                  o_overflow;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_start, i_signed_mode, i_binary_in,
    input  o_bcd_out, o_negative, o_overflow, o_busy, o_done
  );

  modport slave (
    input  i_start, i_signed_mode, i_binary_in,
    output o_bcd_out, o_negative, o_overflow, o_busy, o_done
  );
endinterface

// File: rtl/bin_to_bcd_param.sv
// Sequential shift-add-3 binary-to-BCD converter, one operand bit per clock,
// with signed input, saturation on overflow and a busy/done handshake.
module bin_to_bcd_param #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  bin_to_bcd_param_if.slave    bus
);
  // Scratch layout: {sticky overflow, DIGITS BCD digits, WIDTH operand bits}
  localparam int SW = 4*DIGITS + WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [SW-1:0]       r_scratch;
  logic [SW-1:0]       w_corr;
  logic [SW-1:0]       w_shifted;
  logic [CW-1:0]       r_cnt;
  logic                r_sign;
  logic [WIDTH-1:0]    w_mag;
  logic                w_neg;
  logic                w_capture;
  logic                w_step;
  logic                w_last;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_neg;
  logic                r_ovf;
  logic                r_busy;
  logic                r_done;

  function automatic logic [3:0] f_add3(input logic [3:0] d);
    logic [3:0] res;
    if (d >= 4'd5) begin
      res = d + 4'd3;
    end else begin
      res = d;
    end
    return res;
  endfunction

  // state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_next_state = S_SHIFT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == LAST_CNT) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_SHIFT;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // per-state control decode
  always_comb begin
    w_capture = 1'b0;
    w_step    = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_capture = bus.i_start;
      end
      S_SHIFT: begin
        w_step = 1'b1;
        w_last = (r_cnt == LAST_CNT);
      end
      default: begin
        w_capture = 1'b0;
      end
    endcase
  end

  // operand magnitude; the most-negative value negates to 2^(WIDTH-1) unsigned
  always_comb begin
    w_neg = bus.i_signed_mode & bus.i_binary_in[WIDTH-1];
    if (w_neg) begin
      w_mag = ~bus.i_binary_in + WIDTH'(1);
    end else begin
      w_mag = bus.i_binary_in;
    end
  end

  // digit correction then one-bit left shift; top-digit carry-out is sticky
  always_comb begin
    w_corr = r_scratch;
    for (int d = 0; d < DIGITS; d++) begin
      w_corr[WIDTH + 4*d +: 4] = f_add3(r_scratch[WIDTH + 4*d +: 4]);
    end
    w_shifted = {w_corr[SW-1] | w_corr[SW-2], w_corr[SW-3:0], 1'b0};
  end

  // scratch register, sign flag and bit counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_scratch <= {SW{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_sign    <= 1'b0;
    end else if (w_capture) begin
      r_scratch <= {1'b0, {(4*DIGITS){1'b0}}, w_mag};
      r_cnt     <= {CW{1'b0}};
      r_sign    <= w_neg;
    end else if (w_step) begin
      r_scratch <= w_shifted;
      r_cnt     <= r_cnt + CW'(1);
    end else begin
      r_scratch <= r_scratch;
      r_cnt     <= r_cnt;
      r_sign    <= r_sign;
    end
  end

  // result and handshake registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bcd  <= {(4*DIGITS){1'b0}};
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == S_SHIFT);
      r_done <= w_last;
      if (w_last) begin
        if (w_shifted[SW-1]) begin
          r_bcd <= {DIGITS{4'h9}};
        end else begin
          r_bcd <= w_shifted[SW-2:WIDTH];
        end
        r_neg <= r_sign;
        r_ovf <= w_shifted[SW-1];
      end else begin
        r_bcd <= r_bcd;
        r_neg <= r_neg;
        r_ovf <= r_ovf;
      end
    end
  end

  assign bus.o_bcd_out  = r_bcd;
  assign bus.o_negative = r_neg;
  assign bus.o_overflow = r_ovf;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
endmodule

// File: tb/tb_bin_to_bcd_param.sv
// Directed and random checks of bin_to_bcd_param at 16/4 and 8/3 against an
// arithmetic reference model (divide by ten, saturate, two's-complement magnitude).
module tb_bin_to_bcd_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  bin_to_bcd_param_if #(.WIDTH(16), .DIGITS(4)) a_if ();
  bin_to_bcd_param_if #(.WIDTH(8),  .DIGITS(3)) b_if ();

  bin_to_bcd_param #(.WIDTH(16), .DIGITS(4)) dut_a (.i_clk(clk), .i_reset(rst), .bus(a_if));
  bin_to_bcd_param #(.WIDTH(8),  .DIGITS(3)) dut_b (.i_clk(clk), .i_reset(rst), .bus(b_if));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int w, input int d, input logic [63:0] val, input bit sm,
                                output logic [63:0] bcd, output bit neg, output bit ovf);
    logic [63:0] mag, lim, m;
    neg = sm && val[w-1];
    mag = neg ? ((64'd1 << w) - val) : val;
    lim = 64'd1;
    for (int k = 0; k < d; k++) lim = lim * 64'd10;
    ovf = (mag >= lim);
    bcd = 64'd0;
    m = mag;
    for (int k = 0; k < d; k++) begin
      bcd = bcd | ((ovf ? 64'd9 : (m % 64'd10)) << (4*k));
      m = m / 64'd10;
    end
  endfunction

  task automatic wait_done_a(output int lat, input logic [15:0] prev);
    lat = 0;
    while (a_if.o_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (a_if.o_done !== 1'b1) check("a_hold_during_shift", 64'(a_if.o_bcd_out), 64'(prev));
    end
  endtask

  task automatic run_a(input logic [15:0] val, input bit sm, input string tag);
    logic [63:0] eb;
    bit en, eo;
    int lat;
    logic [15:0] prev;
    model(16, 4, {48'd0, val}, sm, eb, en, eo);
    prev = a_if.o_bcd_out;
    @(negedge clk);
    a_if.i_binary_in = val;
    a_if.i_signed_mode = sm;
    a_if.i_start = 1'b1;
    @(posedge clk); #1;
    a_if.i_start = 1'b0;
    check($sformatf("%s_busy_%h", tag, val), 64'(a_if.o_busy), 64'd1);
    wait_done_a(lat, prev);
    check($sformatf("%s_latency_%h", tag, val), 64'(lat), 64'd16);
    check($sformatf("%s_bcd_%h", tag, val), 64'(a_if.o_bcd_out), eb);
    check($sformatf("%s_neg_%h", tag, val), 64'(a_if.o_negative), 64'(en));
    check($sformatf("%s_ovf_%h", tag, val), 64'(a_if.o_overflow), 64'(eo));
    check($sformatf("%s_busy_in_done_%h", tag, val), 64'(a_if.o_busy), 64'd0);
    @(posedge clk); #1;
    check($sformatf("%s_done_width_%h", tag, val), 64'(a_if.o_done), 64'd0);
  endtask

  task automatic run_b(input logic [7:0] val, input bit sm, input string tag);
    logic [63:0] eb;
    bit en, eo;
    int lat;
    model(8, 3, {56'd0, val}, sm, eb, en, eo);
    @(negedge clk);
    b_if.i_binary_in = val;
    b_if.i_signed_mode = sm;
    b_if.i_start = 1'b1;
    @(posedge clk); #1;
    b_if.i_start = 1'b0;
    lat = 0;
    while (b_if.o_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s_latency_%h", tag, val), 64'(lat), 64'd8);
    check($sformatf("%s_bcd_%h", tag, val), 64'(b_if.o_bcd_out), eb);
    check($sformatf("%s_neg_%h", tag, val), 64'(b_if.o_negative), 64'(en));
    check($sformatf("%s_ovf_%h", tag, val), 64'(b_if.o_overflow), 64'(eo));
  endtask

  initial begin
    int lat;
    int seen;
    logic [15:0] us [11] = '{16'd0, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100,
                             16'd255, 16'd999, 16'd1234, 16'd4095, 16'd9999};
    a_if.i_start = 1'b0; a_if.i_signed_mode = 1'b0; a_if.i_binary_in = 16'd0;
    b_if.i_start = 1'b0; b_if.i_signed_mode = 1'b0; b_if.i_binary_in = 8'd0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_bcd", 64'(a_if.o_bcd_out), 64'd0);
    check("rst_neg", 64'(a_if.o_negative), 64'd0);
    check("rst_ovf", 64'(a_if.o_overflow), 64'd0);
    check("rst_busy", 64'(a_if.o_busy), 64'd0);
    check("rst_done", 64'(a_if.o_done), 64'd0);
    check("rst_b_bcd", 64'(b_if.o_bcd_out), 64'd0);

    foreach (us[i]) run_a(us[i], 1'b0, "unsigned");
    run_a(16'd1234, 1'b0, "unsigned_const");
    check("const_1234", 64'(a_if.o_bcd_out), 64'h1234);
    run_a(16'd65535, 1'b0, "ovf");
    check("const_65535", 64'(a_if.o_bcd_out), 64'h9999);
    run_a(16'd10000, 1'b0, "ovf");
    check("const_10000_ovf", 64'(a_if.o_overflow), 64'd1);
    run_a(16'hFFFF, 1'b1, "signed");
    run_a(16'hFB2E, 1'b1, "signed");
    check("const_m1234", 64'({a_if.o_negative, a_if.o_bcd_out}), 64'h11234);
    run_a(16'h8000, 1'b1, "signed_min");
    check("const_8000", 64'({a_if.o_negative, a_if.o_overflow, a_if.o_bcd_out}), 64'h39999);
    run_a(16'h7FFF, 1'b1, "signed_pos");
    repeat (20) run_a(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), "rand");

    // start pulsed while busy with another operand must be ignored
    @(negedge clk);
    a_if.i_binary_in = 16'd4321; a_if.i_signed_mode = 1'b0; a_if.i_start = 1'b1;
    @(posedge clk); #1;
    a_if.i_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_if.i_binary_in = 16'd1111; a_if.i_start = 1'b1;
    @(posedge clk); #1;
    a_if.i_start = 1'b0;
    check("ignore_busy_still", 64'(a_if.o_busy), 64'd1);
    wait_done_a(lat, a_if.o_bcd_out);
    check("ignore_result", 64'(a_if.o_bcd_out), 64'h4321);
    check("ignore_done_seen", 64'(a_if.o_done), 64'd1);

    // start during the done cycle: next done exactly 17 clocks later
    a_if.i_binary_in = 16'd777; a_if.i_start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) a_if.i_start = 1'b0;
    end while (a_if.o_done !== 1'b1 && lat < 40);
    check("b2b_period", 64'(lat), 64'd17);
    check("b2b_result", 64'(a_if.o_bcd_out), 64'h0777);
    @(posedge clk); #1;
    check("no_queued_start", 64'(a_if.o_busy), 64'd0);

    // start held high: restarts at every idle edge with current operand
    @(negedge clk);
    a_if.i_binary_in = 16'd42; a_if.i_start = 1'b1;
    @(posedge clk); #1;
    wait_done_a(lat, a_if.o_bcd_out);
    check("held_first", 64'(a_if.o_bcd_out), 64'h0042);
    a_if.i_binary_in = 16'd56;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (a_if.o_done !== 1'b1 && lat < 40);
    a_if.i_start = 1'b0;
    check("held_period", 64'(lat), 64'd17);
    check("held_second", 64'(a_if.o_bcd_out), 64'h0056);

    // reset during shift 7: outputs clear at once, no done afterwards
    @(negedge clk);
    a_if.i_binary_in = 16'hFFFE; a_if.i_signed_mode = 1'b1; a_if.i_start = 1'b1;
    @(posedge clk); #1;
    a_if.i_start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_bcd", 64'(a_if.o_bcd_out), 64'd0);
    check("midrst_busy", 64'(a_if.o_busy), 64'd0);
    check("midrst_neg", 64'(a_if.o_negative), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (a_if.o_done === 1'b1) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    run_a(16'd8765, 1'b0, "after_rst");

    // reparametrised instance
    run_b(8'd255, 1'b0, "b_unsigned");
    check("b_const_255", 64'(b_if.o_bcd_out), 64'h255);
    run_b(8'h80, 1'b1, "b_signed_min");
    check("b_const_m128", 64'({b_if.o_negative, b_if.o_overflow, b_if.o_bcd_out}), 64'h2128);
    repeat (8) run_b(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "b_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_param.md
# bin_to_bcd_param

Parametrised sequential binary-to-BCD converter (shift-add-3 / double dabble), successor to the fixed 16-bit converter in the calculator datapath. It converts a WIDTH-bit operand into DIGITS packed BCD digits at one bit per clock. It adds signed (two's-complement) input, an overflow/saturation flag, and a busy/done handshake that supports back-to-back conversions. It sits between the ALU result register and the 7-segment display driver.

## Interface
- WIDTH, 16: binary input width, ≥ 2.
- DIGITS, 4: number of BCD output digits, ≥ 1.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  conversion request, sampled on clk while idle.
- signed_mode  in  1  1 = binary_in is two's complement; sampled with start.
- binary_in  in  WIDTH  operand; sampled with start.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- negative  out  1  sign of last result (1 only if signed_mode and operand < 0).
- overflow  out  1  magnitude of last operand > 10^DIGITS − 1.
- busy  out  1  conversion in progress; start ignored while high.
- done  out  1  one-cycle pulse: result registers just updated.

## Operation
- States: IDLE, SHIFT.
- IDLE: on start=1 (edge E0), capture magnitude into shift register: signed_mode=1 and binary_in[WIDTH-1]=1 → −binary_in (two's-complement negate, WIDTH bits, unsigned interpretation), sign flag=1; otherwise binary_in, sign flag=0. Clear BCD scratch digits, overflow scratch, bit counter. → SHIFT.
- SHIFT, each cycle: every scratch digit ≥ 5 gets +3; then shift {overflow_carry, digits, binary} left by one bit. Any 1 shifted out of the top digit sets the sticky overflow scratch bit.
- Bit counter counts 1..WIDTH; on the WIDTH-th shift the final result loads directly into output registers and state → IDLE.
- Output load: bcd_out = corrected digits, or all digits = 4'h9 if overflow; negative = sign flag; overflow = scratch bit.
- Edge case: signed 10…0 (most-negative) has magnitude 2^(WIDTH-1); it converts correctly, with overflow if it does not fit.
- bcd_out, negative and overflow hold their values between conversions; they do not change during SHIFT.
- start while busy=1: ignored, with no queueing.
- Reset mid-conversion: immediate return to IDLE; no done pulse; outputs clear.

## Timing
- Reset values: bcd_out=0, negative=0, overflow=0, busy=0, done=0, state IDLE, counter 0.
- Start accepted at edge E0. busy=1 from after E0 until after E_WIDTH.
- Result registers update and done=1 for exactly the cycle after E_WIDTH. Latency: WIDTH clocks from the start edge to done.
- During the done cycle, state is IDLE and busy=0, so start is accepted at the next edge. Back-to-back period: WIDTH+1 clocks.
- start held high continuously restarts a new conversion at every edge where the block is idle, using the current binary_in and signed_mode.
- Counter width: $clog2(WIDTH+1). Scratch register: 4*DIGITS+WIDTH+1 bits.

## Test plan
- Reset/defaults: assert reset for 2 cycles, release -> all outputs 0. Assert reset at shift 7 of a conversion -> outputs 0 immediately, no done pulse, and the next conversion is correct.
- Unsigned sweep (WIDTH=16, DIGITS=4): 0, 1, 9, 10, 99, 100, 255, 999, 1234, 4095, 9999 -> bcd_out 0000, 0001, 0009, 0010, 0099, 0100, 0255, 0999, 1234, 4095, 9999 with overflow=0 and negative=0; done exactly 16 clocks after each start edge.
- Overflow: unsigned 65535 -> bcd_out 16'h9999, overflow=1. Unsigned 10000 -> 9999, overflow=1.
- Signed: 16'hFFFF -> 0001, negative=1. 16'hFB2E (−1234) -> 1234, negative=1. 16'h8000 -> 9999, overflow=1, negative=1. 16'h7FFF unsigned-path with signed_mode=1 -> 9999, overflow=1, negative=0.
- Handshake: pulse start during busy with a different operand -> ignored, first result unchanged. Start during the done cycle -> second done exactly 17 clocks after the first.
- Reparametrised instance WIDTH=8, DIGITS=3: 255 -> 12'h255 in 8 clocks. Signed 8'h80 -> 128, negative=1, overflow=0.
